gpio_event_capture: RTL and testbench

Captures debounced edge events from GPIO pad inputs (`gpio_in`) and queues them for the user project, the receive-side counterpart to the user logic that drives `gpio_out`. Each monitored pin is synchronized, debounced, and edge-detected. Enabled rising/falling transitions become timestamped events in a small FIFO, which a valid/ready consumer drains. It sits inside `openframe_project_wrapper` between the pad input bus and user logic.

---
 rtl/gpio_event_pkg.sv | 32 +++
 rtl/gpio_debounce.sv | 72 +++++++
 rtl/gpio_event_capture.sv | 215 +++++++++++++++++++++
 tb/tb_gpio_event_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_pkg.sv
// -----------------------------------------------------------------------------
// gpio_event_pkg
//
// Shared definitions for the GPIO event capture block:
//   TS_WIDTH      width of the free-running timestamp and of event timestamps
//   PIN_BITS_MAX  storage width of the pin index inside a queued event; the top
//                 level uses only the low clog2(WIDTH) bits
//   event_t       one queued event record {pin, rising, stamp}
//   clog2()       index width helper, never returns less than 1 so that a
//                 one-entry range still yields a legal vector
// -----------------------------------------------------------------------------
package gpio_event_pkg;

    localparam int TS_WIDTH     = 16;
    localparam int PIN_BITS_MAX = 8;

    typedef struct packed {
        logic [PIN_BITS_MAX-1:0] pin;     // index of the pin that toggled
        logic                    rising;  // 1 = rising edge, 0 = falling edge
        logic [TS_WIDTH-1:0]     stamp;   // timestamp counter value at the push
    } event_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
//
// One pin of the capture block: a synchronizer chain for the asynchronous pad
// input, followed by a stability counter that only accepts a new level after
// the synchronized value has differed from the current level for
// DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk          single clock
//   resetb       asynchronous active-low reset
//   pin_in       raw pad input, asynchronous to clk
//   level        debounced level
//   edge_strobe  high for the one cycle in which level is about to toggle
//                (combinational, so the parent can commit the edge on the same
//                clock edge that updates level)
//   edge_dir     direction of that toggle: 1 = rising, 0 = falling
// -----------------------------------------------------------------------------
module gpio_debounce
    import gpio_event_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetb,
    input  logic pin_in,
    output logic level,
    output logic edge_strobe,
    output logic edge_dir
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;
    logic                   differ;
    logic                   settle;

    assign synced = sync[SYNC_STAGES-1];
    assign differ = synced ^ level;

    // The counter never passes CNT_LAST: it is cleared on the toggle and
    // whenever the synchronized value agrees with level, so any glitch shorter
    // than DEBOUNCE_CYCLES restarts the count from zero.
    assign settle      = differ && (cnt == CNT_LAST);
    assign edge_strobe = settle;
    assign edge_dir    = ~level;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin_in};
            if (settle) begin
                level <= ~level;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gpio_event_capture.sv
// -----------------------------------------------------------------------------
// gpio_event_capture
//
// Receive-side GPIO monitor. Every pin is synchronized and debounced; enabled
// rising/falling transitions of the debounced level become timestamped events
// in a small FIFO drained by a valid/ready consumer.
//
// Ports:
//   clk           single clock
//   resetb        asynchronous active-low reset
//   pin_in        raw pad inputs (WIDTH), asynchronous to clk
//   enable        event recording enable; debouncing runs regardless
//   rise_mask     per pin, 1 = record rising edges
//   fall_mask     per pin, 1 = record falling edges
//   level         debounced pin levels
//   ev_valid      FIFO head holds an event
//   ev_ready      consumer accepts the head event
//   ev_pin        pin index of the head event
//   ev_rising     1 = head event is a rising edge
//   ev_time       timestamp of the head event
//   overflow      sticky: an edge was dropped because its pin was still pending
//   overflow_clr  synchronous clear of overflow (a same-cycle new loss wins)
//
// Data path: debounced edge -> per-pin pending flag -> lowest-index arbiter ->
// FIFO. An edge waits in its pending flag while the FIFO is full, so only a
// second edge on a pin that is already pending is ever lost.
// -----------------------------------------------------------------------------
module gpio_event_capture
    import gpio_event_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic [WIDTH-1:0]        pin_in,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        rise_mask,
    input  logic [WIDTH-1:0]        fall_mask,
    output logic [WIDTH-1:0]        level,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [clog2(WIDTH)-1:0] ev_pin,
    output logic                    ev_rising,
    output logic [TS_WIDTH-1:0]     ev_time,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    localparam int PIN_W = clog2(WIDTH);
    localparam int AW    = clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    // ------------------------------------------------------------------
    // Per-pin synchronizer + debounce
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] edge_strobe;
    logic [WIDTH-1:0] edge_dir;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .resetb      (resetb),
            .pin_in      (pin_in[i]),
            .level       (level[i]),
            .edge_strobe (edge_strobe[i]),
            .edge_dir    (edge_dir[i])
        );
    end

    // An edge is committed only if recording is enabled and the mask for its
    // direction is set; enable/mask changes therefore never touch queued data.
    logic [WIDTH-1:0] commit;
    assign commit = edge_strobe & {WIDTH{enable}} &
                    ((edge_dir & rise_mask) | (~edge_dir & fall_mask));

    // ------------------------------------------------------------------
    // Timestamp, pending flags, arbiter
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_next;
    logic [WIDTH-1:0]    pending;
    logic [WIDTH-1:0]    pend_dir;
    logic [WIDTH-1:0]    pending_nxt;
    logic [WIDTH-1:0]    dir_nxt;
    logic [WIDTH-1:0]    taken;
    logic                lost;
    logic                grant_valid;
    logic [PIN_W-1:0]    grant_idx;

    // The event carries the counter value that is loaded on the push edge, so
    // ev_time equals the number of edges since reset at that push.
    assign ts_next = ts + TS_WIDTH'(1);

    // FIFO control, declared here because the arbiter depends on it.
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    event_t           push_ev;
    event_t           head;

    // NOTE: every always_comb output gets a default before any conditional
    // logic; a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from the top so the last hit, the lowest index, wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_valid = 1'b1;
                grant_idx   = PIN_W'(i);
            end
        end
    end

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = grant_valid && (!full || pop);
    assign taken = push ? (WIDTH'(1) << grant_idx) : '0;

    always_comb begin
        pending_nxt = pending;
        dir_nxt     = pend_dir;
        lost        = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit[i]) begin
                if (pending[i] && !taken[i]) begin
                    // Keep the older pending edge; the new one is lost.
                    lost = 1'b1;
                end else begin
                    // Either idle, or the old entry leaves for the FIFO on
                    // this same edge, so the new edge can take its place.
                    pending_nxt[i] = 1'b1;
                    dir_nxt[i]     = edge_dir[i];
                end
            end else if (taken[i]) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        push_ev        = '0;
        push_ev.pin    = PIN_BITS_MAX'(grant_idx);
        push_ev.rising = pend_dir[grant_idx];
        push_ev.stamp  = ts_next;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ts       <= '0;
            pending  <= '0;
            pend_dir <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            ts       <= ts_next;
            pending  <= pending_nxt;
            pend_dir <= dir_nxt;

            if (lost) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event storage
    // ------------------------------------------------------------------
    event_t mem [FIFO_DEPTH];

    // NOTE: the storage array has no reset; emptiness lives in count, and the
    // head fields are gated by ev_valid so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ev;
        end
    end

    assign head      = mem[rd_ptr];
    assign ev_valid  = (count != '0);
    assign ev_pin    = ev_valid ? head.pin[PIN_W-1:0] : '0;
    assign ev_rising = ev_valid & head.rising;
    assign ev_time   = ev_valid ? head.stamp : '0;

    // Upper pin bits are always zero for WIDTH below 2**PIN_BITS_MAX.
    logic head_pin_unused;
    assign head_pin_unused = ^head.pin;

endmodule

// File: tb/tb_gpio_event_capture.sv
// -----------------------------------------------------------------------------
// tb_gpio_event_capture
//
// Self-checking bench for gpio_event_capture with default parameters. Expected
// events are pushed onto a scoreboard queue when pin stimulus is driven and
// compared in order as the consumer pops them. A stimulus table covers the
// mask/enable combinations; hand-written sequences cover latency, glitch
// rejection, FIFO full/overflow and timestamp wrap with a mid-run reset.
// -----------------------------------------------------------------------------
module tb_gpio_event_capture;

    logic        clk = 1'b0;
    logic        resetb;
    logic [3:0]  pin_in;
    logic        enable;
    logic [3:0]  rise_mask;
    logic [3:0]  fall_mask;
    logic [3:0]  level;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_pin;
    logic        ev_rising;
    logic [15:0] ev_time;
    logic        overflow;
    logic        overflow_clr;

    always #5 clk = ~clk;

    gpio_event_capture #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .pin_in       (pin_in),
        .enable       (enable),
        .rise_mask    (rise_mask),
        .fall_mask    (fall_mask),
        .level        (level),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_pin       (ev_pin),
        .ev_rising    (ev_rising),
        .ev_time      (ev_time),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    typedef struct {
        int          pin;
        logic        rising;
        logic [15:0] stamp;
    } exp_ev_t;

    typedef struct {
        logic [3:0] pins;
        logic       en;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] exp_level;
    } vec_t;

    exp_ev_t    exp_q[$];
    vec_t       vecs[10];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [3:0] cur_pins;

    // Edges since reset release: the timestamp the DUT should report.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new pin pattern and configuration. With expect_ev set, each
    // enabled transition is queued in pin order with push time N+19+k
    // (2 sync edges, 16 debounce edges, 1 push edge, one push per cycle).
    task automatic apply(input logic [3:0] pins, input logic en,
                         input logic [3:0] rm, input logic [3:0] fm,
                         input bit expect_ev, input int hold);
        int      k;
        exp_ev_t e;
        k = 0;
        if (expect_ev) begin
            for (int i = 0; i < 4; i++) begin
                if (pins[i] != cur_pins[i] && en && (pins[i] ? rm[i] : fm[i])) begin
                    e.pin    = i;
                    e.rising = pins[i];
                    e.stamp  = 16'(cyc + 19 + k);
                    exp_q.push_back(e);
                    k++;
                end
            end
        end
        pin_in    = pins;
        enable    = en;
        rise_mask = rm;
        fall_mask = fm;
        cur_pins  = pins;
        step(hold);
    endtask

    // Scoreboard consumer: compare every popped event against the queue.
    always @(negedge clk) begin
        exp_ev_t e;
        if (resetb === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_event: got pin %0d rising %0b time 0x%0h, expected no event",
                         ev_pin, ev_rising, ev_time);
            end else begin
                e = exp_q.pop_front();
                check("sb_pin",    32'(ev_pin),    32'(e.pin));
                check("sb_rising", 32'(ev_rising), 32'(e.rising));
                check("sb_time",   32'(ev_time),   32'(e.stamp));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ev_t e;

        //           pins     en    rise   fall   level
        vecs[0] = '{4'b0000, 1'b1, 4'hF,  4'hF,  4'b0000};  // pin0, pin1 fall
        vecs[1] = '{4'b1101, 1'b1, 4'hF,  4'hF,  4'b1101};  // 0,2,3 rise together
        vecs[2] = '{4'b0000, 1'b1, 4'hF,  4'hF,  4'b0000};  // 0,2,3 fall together
        vecs[3] = '{4'b0100, 1'b1, 4'hF,  4'h0,  4'b0100};  // pin2 rise recorded
        vecs[4] = '{4'b0000, 1'b1, 4'hF,  4'h0,  4'b0000};  // pin2 fall masked
        vecs[5] = '{4'b1111, 1'b0, 4'hF,  4'hF,  4'b1111};  // disabled, level follows
        vecs[6] = '{4'b0000, 1'b0, 4'hF,  4'hF,  4'b0000};  // disabled, level follows
        vecs[7] = '{4'b0010, 1'b1, 4'h0,  4'hF,  4'b0010};  // rise masked
        vecs[8] = '{4'b0000, 1'b1, 4'hF,  4'b0010, 4'b0000}; // pin1 fall recorded
        vecs[9] = '{4'b1010, 1'b1, 4'hF,  4'hF,  4'b1010};  // pin1, pin3 rise

        resetb       = 1'b0;
        pin_in       = 4'b0000;
        enable       = 1'b1;
        rise_mask    = 4'hF;
        fall_mask    = 4'hF;
        ev_ready     = 1'b0;
        overflow_clr = 1'b0;
        cur_pins     = 4'b0000;
        #12;

        // Reset state
        check("rst_level",     32'(level),     32'h0);
        check("rst_ev_valid",  32'(ev_valid),  32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        check("rst_ev_pin",    32'(ev_pin),    32'h0);
        check("rst_ev_rising", 32'(ev_rising), 32'h0);
        check("rst_ev_time",   32'(ev_time),   32'h0);

        // Latency: pin0 rises with reset release, level at edge 18, event at 19
        e.pin = 0; e.rising = 1'b1; e.stamp = 16'd19;
        exp_q.push_back(e);
        resetb   = 1'b1;
        pin_in   = 4'b0001;
        cur_pins = 4'b0001;
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("lat_level_edge17", 32'(level[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("lat_level_edge18", 32'(level[0]), 32'h1);
        check("lat_valid_edge18", 32'(ev_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_edge19", 32'(ev_valid),  32'h1);
        check("lat_pin",          32'(ev_pin),    32'h0);
        check("lat_rising",       32'(ev_rising), 32'h1);
        check("lat_time",         32'(ev_time),   32'd19);
        @(posedge clk);
        #1;
        ev_ready = 1'b1;
        step(3);
        check("lat_drained", 32'(exp_q.size()), 32'h0);

        // Glitch rejection: three 15-cycle highs on pin1, then a real rise
        for (int g = 0; g < 3; g++) begin
            pin_in[1] = 1'b1;
            step(15);
            pin_in[1] = 1'b0;
            step(5);
        end
        check("glitch_level1", 32'(level[1]), 32'h0);
        e.pin = 1; e.rising = 1'b1; e.stamp = 16'(cyc + 19);
        exp_q.push_back(e);
        pin_in[1]   = 1'b1;
        cur_pins[1] = 1'b1;
        step(17);
        check("glitch_restart_edge17", 32'(level[1]), 32'h0);
        step(1);
        check("glitch_restart_edge18", 32'(level[1]), 32'h1);
        step(4);

        // Table: masks, enable, simultaneous edges
        for (int v = 0; v < 10; v++) begin
            apply(vecs[v].pins, vecs[v].en, vecs[v].rise, vecs[v].fall, 1'b1, 25);
            check($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
        end
        check("table_queue_empty", 32'(exp_q.size()), 32'h0);

        // FIFO full: 8 events held, pin1 waits pending, second pin1 edge lost
        ev_ready = 1'b0;
        apply(4'b0101, 1'b1, 4'hF, 4'hF, 1'b1, 25);  // 4 events
        apply(4'b1111, 1'b1, 4'hF, 4'hF, 1'b1, 25);  // pin1, pin3 rise
        apply(4'b1101, 1'b1, 4'hF, 4'hF, 1'b1, 25);  // pin1 fall
        apply(4'b0101, 1'b1, 4'hF, 4'hF, 1'b1, 25);  // pin3 fall -> 8 queued
        check("full_valid", 32'(ev_valid), 32'h1);
        apply(4'b0111, 1'b1, 4'hF, 4'hF, 1'b0, 25);  // pin1 rise, held pending
        check("full_no_overflow", 32'(overflow), 32'h0);
        apply(4'b0101, 1'b1, 4'hF, 4'hF, 1'b0, 25);  // pin1 fall while pending
        check("overflow_set",      32'(overflow), 32'h1);
        check("level_after_drop",  32'(level),    32'b0101);
        // The first pop frees a slot and pushes pending pin1 on that edge.
        e.pin = 1; e.rising = 1'b1; e.stamp = 16'(cyc + 1);
        exp_q.push_back(e);
        ev_ready = 1'b1;
        step(12);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
        check("drain_valid_low",   32'(ev_valid),     32'h0);
        check("overflow_sticky",   32'(overflow),     32'h1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("overflow_cleared", 32'(overflow), 32'h0);

        // Timestamp wrap: pushes land on 0xFFFF and 0x0000
        while (cyc < 65516) step(1);
        ev_ready = 1'b0;
        apply(4'b1111, 1'b1, 4'hF, 4'hF, 1'b1, 22);  // pin1 then pin3
        check("wrap_valid",  32'(ev_valid), 32'h1);
        check("wrap_pin_a",  32'(ev_pin),   32'h1);
        check("wrap_time_a", 32'(ev_time),  32'hFFFF);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        check("wrap_valid_b", 32'(ev_valid), 32'h1);
        check("wrap_pin_b",   32'(ev_pin),   32'h3);
        check("wrap_time_b",  32'(ev_time),  32'h0000);

        // Asynchronous reset with an event still queued
        #2;
        resetb = 1'b0;
        #1;
        check("async_rst_valid", 32'(ev_valid), 32'h0);
        check("async_rst_level", 32'(level),    32'h0);
        check("async_rst_time",  32'(ev_time),  32'h0);
        exp_q.delete();
        #10;
        resetb = 1'b1;
        step(2);
        check("post_rst_valid", 32'(ev_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
